instr_seq: RTL
==============

INSTR_SEQ -- requirements
Module: instr_seq

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port instr_valid, input, 1, instruction memory returns a valid word this cycle.
REQ-004 SHALL have port instr, input, 16, instruction word; sampled only when instr_valid=1 in FETCH.
REQ-005 SHALL have port cout, input, 1, registered carry from the downstream register/ALU datapath.
REQ-006 SHALL have port imem_req, output, 1, fetch request; high only in FETCH.
REQ-007 SHALL have port imem_addr, output, 16, current PC.
REQ-008 SHALL have port sel, output, 1, write-data select to datapath: 0 = d_in, 1 = ALU result.
REQ-009 SHALL have port wr, output, 1, register-file write strobe.
REQ-010 SHALL have port op, output, 2, ALU operation code.
REQ-011 SHALL have ports rd_addr_a, rd_addr_b, wr_addr, output, 3 each, register addresses.
REQ-012 SHALL have port d_in, output, 16, immediate data to datapath.
REQ-013 SHALL have port halted, output, 1, high while in HALT.

Function
REQ-014 SHALL decode instr[15:13] as: 000 NOP; 001 ALU; 010 LDI; 011 JMP; 100 JC; 111 HALT; 101/110 treated as NOP.
REQ-015 ALU fields SHALL be: op = [12:11], wr_addr = [10:8], rd_addr_a = [7:5], rd_addr_b = [4:2]; [1:0] ignored.
REQ-016 LDI fields SHALL be: wr_addr = [12:10], d_in = {6'b0, [9:0]}.
REQ-017 JMP/JC offset SHALL be instr[12:0] sign-extended to 16 bits.
REQ-018 SHALL latch the accepted word into a 16-bit IR; all datapath outputs are decoded from IR only and stay stable for the whole instruction.
REQ-019 FSM states SHALL be FETCH, EXEC, FLAG, HALT.
REQ-020 FETCH: imem_req=1, wr=0; on instr_valid=1 load IR and go to EXEC; otherwise stay (no timeout).
REQ-021 EXEC, ALU: sel=1, wr=1 for exactly one cycle, PC <= PC+1, next state FLAG.
REQ-022 EXEC, LDI: sel=0, wr=1 for exactly one cycle, PC <= PC+1, next state FETCH.
REQ-023 EXEC, NOP/illegal: wr=0, PC <= PC+1, next state FETCH.
REQ-024 EXEC, JMP: wr=0, PC <= PC + sext(offset), next state FETCH.
REQ-025 EXEC, JC: if cflag=1 then PC <= PC + sext(offset), else PC <= PC+1; wr=0; next state FETCH.
REQ-026 EXEC, HALT: wr=0, PC unchanged, next state HALT.
REQ-027 FLAG: cflag <= cout (the carry of the ALU write just completed), wr=0, next state FETCH.
REQ-028 cflag SHALL change only in FLAG; LDI, JMP, JC and NOP SHALL leave it unchanged.
REQ-029 HALT SHALL be terminal: halted=1, imem_req=0, wr=0, until reset.
REQ-030 PC arithmetic SHALL be 16-bit modulo: 0xFFFF+1 = 0x0000; a negative offset below 0 wraps.
REQ-031 Offset 0 on a taken jump SHALL re-fetch the same address (self-loop is legal).
REQ-032 wr SHALL never be high outside EXEC; at most one write per instruction.
REQ-033 Throughput SHALL be: ALU 3 cycles, all other instructions 2 cycles, plus any instr_valid wait cycles.

Reset
REQ-034 While reset=1, asynchronously: state=FETCH, PC=0, IR=0, cflag=0, and all outputs 0 except imem_req=1.
REQ-035 Reset asserted in any state, including mid-EXEC, SHALL abort the instruction immediately; any wr pulse ends with reset assertion.
REQ-036 After reset deassertion the first fetch SHALL be from address 0x0000.

Verification
REQ-037 Reset, then instr_valid=1 with 0x4005 (LDI r0,5) -> one cycle with wr=1, sel=0, wr_addr=0, d_in=0x0005; next imem_addr=0x0001.
REQ-038 Send 0x2100 (ALU op=0, wd=r1, ra=r0, rb=r0) with cout=1 in FLAG -> wr=1, sel=1, op=00, wr_addr=1 for one cycle; cflag=1; next fetch at PC+1.
REQ-039 With cflag=0, JC +4 (0x8004) at PC=3 -> next imem_addr=4; with cflag=1 -> next imem_addr=7.
REQ-040 JMP -1 (0x7FFF) at PC=0 -> next imem_addr=0xFFFF; NOP there -> next imem_addr=0x0000.
REQ-041 Hold instr_valid=0 for 5 cycles in FETCH -> imem_req stays 1, wr stays 0, PC unchanged; then HALT (0xE000) -> halted=1, imem_req=0 permanently.
REQ-042 Assert reset during the EXEC cycle of an LDI -> wr drops immediately, PC=0, and fetch restarts at 0x0000 after release.

Source files
------------

// File: rtl/instr_seq.sv
`timescale 1ns/1ps
// instr_seq: multi-cycle FETCH/EXEC/FLAG/HALT sequencer that latches a 16-bit
// instruction into IR and drives register-file/ALU controls decoded from it.
module instr_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    input  logic        cout,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    output logic        sel,
    output logic        wr,
    output logic [1:0]  op,
    output logic [2:0]  rd_addr_a,
    output logic [2:0]  rd_addr_b,
    output logic [2:0]  wr_addr,
    output logic [15:0] d_in,
    output logic        halted,
    output logic [1:0]  state_dbg
);

    // Fetch handshake: imem_req acts as ready; a word transfers on a rising edge
    // where imem_req && instr_valid, and instr is ignored on every other edge.
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_FLAG, S_HALT} state_t;

    localparam logic [2:0] OPC_ALU  = 3'b001;
    localparam logic [2:0] OPC_LDI  = 3'b010;
    localparam logic [2:0] OPC_JMP  = 3'b011;
    localparam logic [2:0] OPC_JC   = 3'b100;
    localparam logic [2:0] OPC_HALT = 3'b111;

    state_t      state, state_nx;
    logic [15:0] pc, pc_nx;
    logic [15:0] ir;
    logic        cflag;
    logic [2:0]  opc;
    logic [15:0] offset;
    logic        unused_ir_bits;

    assign opc            = ir[15:13];
    assign offset         = {{3{ir[12]}}, ir[12:0]};
    assign unused_ir_bits = ^ir[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nx;
        end
    end

    // PC advances only in EXEC; the carry flag only samples cout in FLAG.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= 16'd0;
            ir    <= 16'd0;
            cflag <= 1'b0;
        end else begin
            if (state == S_FETCH && instr_valid) ir <= instr;
            if (state == S_EXEC) pc <= pc_nx;
            if (state == S_FLAG) cflag <= cout;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        case (state)
            S_FETCH: if (instr_valid) state_nx = S_EXEC;
            S_EXEC: begin
                state_nx = S_FETCH;
                pc_nx    = pc + 16'd1;
                case (opc)
                    OPC_ALU:  state_nx = S_FLAG;
                    OPC_JMP:  pc_nx = pc + offset;
                    OPC_JC:   if (cflag) pc_nx = pc + offset;
                    OPC_HALT: begin
                        state_nx = S_HALT;
                        pc_nx    = pc;
                    end
                    default: ;
                endcase
            end
            S_FLAG:  state_nx = S_FETCH;
            S_HALT:  state_nx = S_HALT;
            default: state_nx = S_FETCH;
        endcase
    end

    // Datapath fields come from IR alone, so they hold for the whole instruction.
    always_comb begin
        imem_req  = (state == S_FETCH);
        halted    = (state == S_HALT);
        wr        = 1'b0;
        sel       = 1'b0;
        op        = 2'd0;
        rd_addr_a = 3'd0;
        rd_addr_b = 3'd0;
        wr_addr   = 3'd0;
        d_in      = 16'd0;
        case (opc)
            OPC_ALU: begin
                sel       = 1'b1;
                op        = ir[12:11];
                wr_addr   = ir[10:8];
                rd_addr_a = ir[7:5];
                rd_addr_b = ir[4:2];
                wr        = (state == S_EXEC);
            end
            OPC_LDI: begin
                wr_addr = ir[12:10];
                d_in    = {6'b0, ir[9:0]};
                wr      = (state == S_EXEC);
            end
            default: ;
        endcase
    end

    assign imem_addr = pc;
    assign state_dbg = state;

endmodule
